// File: rtl/sum_stats_pkg.sv
// Shared types and widths for the sum_stats window accumulator.
//   SUM_W       width of one adder sum sample
//   DEF_WINDOW  window size that result_t is sized for
//   status_e    per-sample status code from the adder stage
//   result_t    one window result as held in the output register
package sum_stats_pkg;

    localparam int unsigned SUM_W      = 8;
    localparam int unsigned DEF_WINDOW = 16;
    localparam int unsigned RES_CNT_W  = $clog2(DEF_WINDOW + 1);
    localparam int unsigned RES_ACC_W  = SUM_W + RES_CNT_W;

    typedef enum logic [1:0] {
        ST_ZERO  = 2'd0,
        ST_MAX   = 2'd1,
        ST_OTHER = 2'd2,
        ST_RSVD  = 2'd3
    } status_e;

    typedef struct packed {
        logic [RES_ACC_W-1:0] total;
        logic [RES_CNT_W-1:0] zero_cnt;
        logic [RES_CNT_W-1:0] max_cnt;
        logic [RES_CNT_W-1:0] samples;
    } result_t;

endpackage

// File: rtl/sum_stats.sv
// Window statistics over the registered adder's sum/status stream.
// Accumulates WINDOW samples (or fewer when in_last closes early) and holds
// the total, zero-count, max-count and sample count in an output register
// until the consumer takes it.
//
// Optional feature macro: SUM_STATS_CHECK_EN
//   defined   -> err is a sticky flag for reserved status or status/sum disagreement
//   undefined -> err is tied low, no check logic
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake
//   in_sum, in_status        sample payload
//   in_last                  close the current window with this sample
//   out_valid/out_ready      result handshake
//   out_total                window sum of in_sum (ACC_W bits)
//   out_zero_cnt             samples with status ST_ZERO
//   out_max_cnt              samples with status ST_MAX
//   out_samples              samples in the window
//   err                      sticky check flag
module sum_stats
    import sum_stats_pkg::*;
#(
    parameter int unsigned WINDOW = DEF_WINDOW
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [SUM_W-1:0]                     in_sum,
    input  logic [1:0]                           in_status,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [SUM_W+$clog2(WINDOW+1)-1:0]    out_total,
    output logic [$clog2(WINDOW+1)-1:0]          out_zero_cnt,
    output logic [$clog2(WINDOW+1)-1:0]          out_max_cnt,
    output logic [$clog2(WINDOW+1)-1:0]          out_samples,
    output logic                                 err
);

    localparam int unsigned CNT_W = $clog2(WINDOW + 1);
    localparam int unsigned ACC_W = SUM_W + CNT_W;

    // result_t is fixed-width in the package, so the window must match it.
    if (WINDOW != DEF_WINDOW || WINDOW < 2) begin : g_bad_window
        $error("sum_stats: WINDOW must equal sum_stats_pkg::DEF_WINDOW");
    end

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_zcnt;
    logic [CNT_W-1:0] r_mcnt;
    logic [CNT_W-1:0] r_idx;
    logic             r_out_valid;
    result_t          r_res;

    status_e          w_status;
    logic             w_accept;
    logic             w_close;
    logic             w_is_zero;
    logic             w_is_max;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_zcnt_nxt;
    logic [CNT_W-1:0] w_mcnt_nxt;
    logic [CNT_W-1:0] w_idx_nxt;

    // The result slot frees in the same cycle it drains.
    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_status   = status_e'(in_status);
    assign w_is_zero  = (w_status == ST_ZERO);
    assign w_is_max   = (w_status == ST_MAX);
    assign w_close    = w_accept && ((r_idx == CNT_W'(WINDOW - 1)) || in_last);

    // Running totals including the sample being accepted this cycle.
    assign w_acc_nxt  = r_acc + ACC_W'(in_sum);
    assign w_zcnt_nxt = r_zcnt + CNT_W'(w_is_zero);
    assign w_mcnt_nxt = r_mcnt + CNT_W'(w_is_max);
    assign w_idx_nxt  = r_idx + CNT_W'(1);

    // Window accumulators; a close restarts them so the next sample opens a fresh window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_zcnt <= '0;
            r_mcnt <= '0;
            r_idx  <= '0;
        end else if (w_close) begin
            r_acc  <= '0;
            r_zcnt <= '0;
            r_mcnt <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_acc  <= w_acc_nxt;
            r_zcnt <= w_zcnt_nxt;
            r_mcnt <= w_mcnt_nxt;
            r_idx  <= w_idx_nxt;
        end
    end

    // Output register; a close loads even while draining, so there is no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_res       <= '0;
        end else if (w_close) begin
            r_out_valid    <= 1'b1;
            r_res.total    <= w_acc_nxt;
            r_res.zero_cnt <= w_zcnt_nxt;
            r_res.max_cnt  <= w_mcnt_nxt;
            r_res.samples  <= w_idx_nxt;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_total    = r_res.total;
    assign out_zero_cnt = r_res.zero_cnt;
    assign out_max_cnt  = r_res.max_cnt;
    assign out_samples  = r_res.samples;

`ifdef SUM_STATS_CHECK_EN
    logic r_err;
    logic w_bad;

    // Reserved status, or status that contradicts the sum value.
    assign w_bad = (w_status == ST_RSVD)
                || (w_is_zero != (in_sum == SUM_W'(0)))
                || (w_is_max  != (in_sum == {SUM_W{1'b1}}));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && w_bad) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sum_stats.sv
// Directed bench for sum_stats: full/mixed/early windows, backpressure,
// mid-window reset and the optional check flag.
module tb_sum_stats;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_sum;
    logic [1:0]  in_status;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_total;
    logic [4:0]  out_zero_cnt;
    logic [4:0]  out_max_cnt;
    logic [4:0]  out_samples;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SUM_STATS_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    sum_stats dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sum       (in_sum),
        .in_status    (in_status),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_total    (out_total),
        .out_zero_cnt (out_zero_cnt),
        .out_max_cnt  (out_max_cnt),
        .out_samples  (out_samples),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int total, input int zc, input int mc, input int ns);
        chk({tag, "_valid"},   32'(out_valid),    32'd1);
        chk({tag, "_total"},   32'(out_total),    32'(total));
        chk({tag, "_zero"},    32'(out_zero_cnt), 32'(zc));
        chk({tag, "_max"},     32'(out_max_cnt),  32'(mc));
        chk({tag, "_samples"}, 32'(out_samples),  32'(ns));
    endtask

    // Present one sample and return #1 after the edge that accepts it.
    task automatic push(input logic [7:0] s, input logic [1:0] st, input logic last);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_sum    = s;
        in_status = st;
        in_last   = last;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"},   32'(out_valid),    32'd0);
        chk({tag, "_total"},   32'(out_total),    32'd0);
        chk({tag, "_zero"},    32'(out_zero_cnt), 32'd0);
        chk({tag, "_max"},     32'(out_max_cnt),  32'd0);
        chk({tag, "_samples"}, 32'(out_samples),  32'd0);
        chk({tag, "_err"},     32'(err),          32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = 8'd0;
        in_status = 2'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_cleared("reset");
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Full window of 16 x 10.
        for (int i = 0; i < 16; i++) push(8'd10, 2'b10, 1'b0);
        chk_res("full", 160, 0, 0, 16);
        @(posedge clk);
        #1;
        chk("full_drain_valid", 32'(out_valid), 32'd0);

        // Mixed: 4 zero, 2 max, 10 x 1.
        for (int i = 0; i < 16; i++) begin
            if (i < 4)      push(8'h00, 2'b00, 1'b0);
            else if (i < 6) push(8'hFF, 2'b01, 1'b0);
            else            push(8'h01, 2'b10, 1'b0);
        end
        chk_res("mixed", 520, 4, 2, 16);

        // Early close after 3 samples, then a 2-sample window from zero.
        push(8'd5, 2'b10, 1'b0);
        push(8'd6, 2'b10, 1'b0);
        push(8'd7, 2'b10, 1'b1);
        chk_res("early", 18, 0, 0, 3);
        push(8'd1, 2'b10, 1'b0);
        push(8'd2, 2'b10, 1'b1);
        chk_res("restart", 3, 0, 0, 2);

        // in_last on the 16th sample: one close with 16 samples.
        for (int i = 0; i < 16; i++) push(8'd2, 2'b10, 1'b0 | (i == 15));
        chk_res("last16", 32, 0, 0, 16);
        @(posedge clk);
        #1;
        chk("last16_single", 32'(out_valid), 32'd0);

        // Backpressure with a pending closing sample.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(8'd3, 2'b10, 1'b0);
        chk_res("bp", 48, 0, 0, 16);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sum    = 8'd9;
        in_status = 2'b10;
        in_last   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_total",    32'(out_total), 32'd48);
            chk("bp_samples",  32'(out_samples), 32'd16);
            chk("bp_valid",    32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_res("b2b", 9, 0, 0, 1);
        @(posedge clk);
        #1;
        chk("b2b_drain_valid", 32'(out_valid), 32'd0);

        // Reset mid-window (fields non-zero beforehand).
        for (int i = 0; i < 7; i++) push(8'd4, 2'b10, 1'b0);
        chk("pre_rst_err", 32'(err), 32'd0);
        do_reset();
        chk_cleared("midrst");
        for (int i = 0; i < 16; i++) push(8'd1, 2'b10, 1'b0);
        chk_res("post_rst", 16, 0, 0, 16);

        // Status/sum disagreement.
        push(8'd0, 2'b10, 1'b1);
        chk("err_set", 32'(err), 32'(ERR_EN));
        repeat (5) @(posedge clk);
        #1;
        chk("err_sticky", 32'(err), 32'(ERR_EN));
        push(8'd7, 2'b11, 1'b1);
        chk_res("rsvd", 7, 0, 0, 1);
        chk("rsvd_err", 32'(err), 32'(ERR_EN));
        do_reset();
        chk("err_clear", 32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
